// File: rtl/lj16_serializer.sv
// LJ16 link generator: bck (32fs), lrck and MSB-first left-justified sdata
// from mclk, fed by a one-entry valid/ready holding register.
//
// Ports:
//   mclk, rst_n   sole clock; synchronous active-low reset
//   in_l, in_r    16-bit two's complement L/R sample pair
//   in_valid      pair on in_l/in_r is valid
//   in_ready      holding register empty (transfer = in_valid & in_ready)
//   bck           bit clock, BCK_DIV mclk per period, 50% duty
//   lrck          0 = left half, 1 = right half
//   sdata         serial data, changes on bck falling edge
//   frame_start   1-mclk pulse on the first mclk of each left half
//   underrun      1-mclk pulse when a frame starts with the holder empty
module lj16_serializer #(
  parameter int BCK_DIV = 8
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [15:0] in_l,
  input  logic [15:0] in_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        bck,
  output logic        lrck,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun
);

  localparam int DW = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(BCK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCK_DIV / 2);

  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sh_q, sh_d;
  logic [31:0]   hold_q, hold_d;
  logic          full_q, full_d;
  logic          rdy_q, rdy_d;
  logic          bck_q, bck_d;
  logic          fs_q, fs_d;
  logic          ur_q, ur_d;

  logic div_end;
  logic load;
  logic xfer;

  always_comb begin
    div_end = (div_q == DIV_LAST);
    load    = div_end && (bit_q == 5'd31);
    xfer    = in_valid && rdy_q;

    div_d  = div_end ? '0 : div_q + DW'(1);
    bit_d  = div_end ? bit_q + 5'd1 : bit_q;
    sh_d   = sh_q;
    hold_d = hold_q;
    full_d = full_q;
    fs_d   = 1'b0;
    ur_d   = 1'b0;

    // sdata only moves when bck is about to fall
    if (div_end) begin
      sh_d = sh_q << 1;
    end

    if (load) begin
      fs_d = 1'b1;
      if (full_q) begin
        sh_d   = hold_q;
        full_d = 1'b0;
      end else begin
        sh_d = '0;
        ur_d = 1'b1;
      end
    end

    // xfer implies the holder was empty, so it never races the load
    if (xfer) begin
      hold_d = {in_l, in_r};
      full_d = 1'b1;
    end

    rdy_d = ~full_d;
    bck_d = (div_d >= DIV_HALF);
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
      rdy_q  <= 1'b0;
      bck_q  <= 1'b0;
      fs_q   <= 1'b0;
      ur_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      hold_q <= hold_d;
      full_q <= full_d;
      rdy_q  <= rdy_d;
      bck_q  <= bck_d;
      fs_q   <= fs_d;
      ur_q   <= ur_d;
    end
  end

  assign in_ready    = rdy_q;
  assign bck         = bck_q;
  assign lrck        = bit_q[4];
  assign sdata       = sh_q[31];
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_lj16_serializer.sv
// Bench for lj16_serializer: two instances (BCK_DIV 8 and 2) checked
// every mclk against a frame-level model of the LJ16 link.
module tb_lj16_serializer;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_l[2];
  logic [15:0] in_r[2];
  logic        in_valid[2];
  logic        in_ready[2];
  logic        bck[2];
  logic        lrck[2];
  logic        sdata[2];
  logic        fs[2];
  logic        ur[2];

  always #5 mclk = ~mclk;

  lj16_serializer #(.BCK_DIV(8)) u8 (
    .mclk(mclk), .rst_n(rst_n),
    .in_l(in_l[0]), .in_r(in_r[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .bck(bck[0]), .lrck(lrck[0]), .sdata(sdata[0]),
    .frame_start(fs[0]), .underrun(ur[0])
  );

  lj16_serializer #(.BCK_DIV(2)) u2 (
    .mclk(mclk), .rst_n(rst_n),
    .in_l(in_l[1]), .in_r(in_r[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .bck(bck[1]), .lrck(lrck[1]), .sdata(sdata[1]),
    .frame_start(fs[1]), .underrun(ur[1])
  );

  int vecs = 0;
  int errs = 0;
  // t = mclk edges since the last reset edge (state index)
  int t = 0;
  int cyc = 0;
  bit started = 1'b0;
  // frame contents keyed by instance*1e6 + frame index
  logic [31:0] mp[int];
  int lastf[2] = '{-1, -1};
  logic [31:0] cap[2] = '{32'h0, 32'h0};
  bit capd[2] = '{1'b0, 1'b0};
  logic pbck[2] = '{1'b0, 1'b0};
  int lastfs[2] = '{0, 0};
  int fscnt[2] = '{0, 0};

  int D, FR, f, b, k;
  logic [31:0] w;
  bit has;

  task automatic chk(string nm, int g, logic got, logic exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s[%0d] t=%0d got %b want %b", nm, g, t, got, exp);
    end
  endtask

  task automatic chk32(string nm, int g, logic [31:0] got,
                       logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s[%0d] got %h want %h", nm, g, got, exp);
    end
  endtask

  always @(negedge mclk) begin
    cyc++;
    if (started) begin
      for (int g = 0; g < 2; g++) begin
        D   = (g == 0) ? 8 : 2;
        FR  = 32 * D;
        f   = t / FR;
        b   = (t / D) % 32;
        k   = g * 1000000 + f;
        has = mp.exists(k);
        w   = has ? mp[k] : 32'h0;
        chk("bck", g, bck[g], (t % D) >= (D / 2));
        chk("lrck", g, lrck[g], b >= 16);
        chk("sdata", g, sdata[g], w[31 - b]);
        chk("frame_start", g, fs[g], (t > 0) && (t % FR == 0));
        chk("underrun", g, ur[g],
            (t > 0) && (t % FR == 0) && !has);
        chk("in_ready", g, in_ready[g], (t >= 1) && (lastf[g] <= f));

        // literal pin: first loaded frame as seen on bck rising edges
        if (!capd[g] && f == 1 && bck[g] && !pbck[g])
          cap[g] = {cap[g][30:0], sdata[g]};
        if (!capd[g] && t == 2 * FR) begin
          chk32("frame1_word", g, cap[g], 32'hA5C30F01);
          capd[g] = 1'b1;
        end
        pbck[g] = bck[g];

        if (fs[g]) begin
          fscnt[g]++;
          if (fscnt[g] == 2)
            chk32("fs_period", g, 32'(cyc - lastfs[g]),
                  (g == 0) ? 32'd256 : 32'd64);
          lastfs[g] = cyc;
        end

        // a pair taken in the load cycle misses the frame being loaded
        if (rst_n && in_valid[g] && in_ready[g]) begin
          f = (t + 1) / FR + 1;
          mp[g * 1000000 + f] = {in_l[g], in_r[g]};
          lastf[g] = f;
        end
      end
    end
    if (!rst_n) begin
      t = 0;
      mp.delete();
      lastf = '{-1, -1};
      started = 1'b1;
    end else if (started) begin
      t++;
    end
  end

  task automatic push(int g, logic [15:0] l, logic [15:0] r);
    in_l[g] = l;
    in_r[g] = r;
    in_valid[g] = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (in_ready[g]) begin
        @(posedge mclk);
        #1;
        in_valid[g] = 1'b0;
        return;
      end
      @(posedge mclk);
      #1;
    end
    $display("FAIL push_timeout[%0d] in_ready stuck at 0", g);
    $fatal(1, "push timeout");
  endtask

  task automatic wait_fs(int g);
    for (int i = 0; i < 600; i++) begin
      @(posedge mclk);
      #1;
      if (fs[g]) return;
    end
    $display("FAIL fs_timeout[%0d] no frame_start", g);
    $fatal(1, "frame_start timeout");
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      in_l[g] = '0;
      in_r[g] = '0;
      in_valid[g] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge mclk);
    #1 rst_n = 1'b1;

    // one pair each, then idle: frame 1 data, frame 2 underrun
    push(0, 16'hA5C3, 16'h0F01);
    push(1, 16'hA5C3, 16'h0F01);
    repeat (800) @(posedge mclk);
    #1;

    // valid held high with changing data
    in_valid[0] = 1'b1;
    in_valid[1] = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      in_l[0] = 16'(i * 37);
      in_r[0] = ~16'(i * 53);
      in_l[1] = 16'(i * 91 + 5);
      in_r[1] = 16'(i);
      @(posedge mclk);
      #1;
    end
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;

    // load a frame, buffer another, reset during bit 20
    wait_fs(0);
    push(0, 16'h1234, 16'h5678);
    wait_fs(0);
    push(0, 16'hABCD, 16'hEF01);
    for (int i = 0; i < 300; i++) begin
      if (t % 256 == 163) break;
      @(posedge mclk);
      #1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge mclk);
    #1 rst_n = 1'b1;
    repeat (600) @(posedge mclk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
